// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM state and coin encoding for the vending controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_e;
  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_1    = 2'd1;
  localparam logic [1:0] COIN_2    = 2'd2;
  localparam logic [1:0] COIN_BAD  = 2'd3;
endpackage

// File: rtl/vend_prio_arb.sv
// vend_prio_arb: fixed-priority arbiter, lowest unmasked request wins
module vend_prio_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    valid_o = |(req_i & mask_i);
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i] && mask_i[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending controller - credit, arbitration, dispense handshake, change return
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int N_PROD       = 4,
  parameter int PRICE        = 3,
  parameter int CREDIT_W     = 4,
  parameter int STOCK_W      = 3,
  parameter int STOCK_INIT   = 2,
  parameter int DISP_TIMEOUT = 8,
  localparam int IW = N_PROD > 1 ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic [N_PROD-1:0]   sel,
  input  logic                cancel,
  input  logic                restock,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [IW-1:0]       disp_id,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_PROD-1:0]   sold_out,
  output logic                fault
);
  localparam int TW = $clog2(DISP_TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PR = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0] CMAX = (CREDIT_W + 1)'(2 ** CREDIT_W - 1);
  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, left;
  logic [STOCK_W-1:0] stock_q [N_PROD];
  logic [STOCK_W-1:0] stock_d [N_PROD];
  logic [N_PROD-1:0] sold_out_q, sold_out_d;
  logic [IW-1:0] disp_id_q, disp_id_d, g_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [CREDIT_W:0] sum;
  logic disp_req_q, disp_req_d, change_q, change_d, reject_q, reject_d, fault_q, fault_d;
  logic g_valid, coin_ok, grant, ack, tmo, restock_ok;
  vend_prio_arb #(.N(N_PROD), .IW(IW)) u_arb (
    .req_i  (sel),
    .mask_i (~sold_out_q),
    .valid_o(g_valid),
    .idx_o  (g_idx)
  );
  assign sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin);
  assign coin_ok = (state_q == IDLE || state_q == CREDIT) && !cancel &&
                   (coin == COIN_1 || coin == COIN_2) && sum <= CMAX;
  assign grant = state_q == CREDIT && !fault_q && credit_q >= PR && g_valid;
  assign ack = state_q == DISPENSE && disp_ack;
  assign tmo = state_q == DISPENSE && !disp_ack && timer_q == TW'(DISP_TIMEOUT - 1);
  assign left = credit_q - PR;
  assign restock_ok = state_q == IDLE && restock;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      credit_q <= '0;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      sold_out_q <= '0;
      disp_req_q <= 1'b0;
      disp_id_q <= '0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
      fault_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      stock_q <= stock_d;
      sold_out_q <= sold_out_d;
      disp_req_q <= disp_req_d;
      disp_id_q <= disp_id_d;
      change_q <= change_d;
      reject_q <= reject_d;
      fault_q <= fault_d;
      timer_q <= timer_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = coin_ok ? CREDIT : IDLE;
      CREDIT:   state_d = grant ? DISPENSE : cancel ? CHANGE : CREDIT;
      DISPENSE: state_d = ack ? (left != '0 ? CHANGE : IDLE) : tmo ? CHANGE : DISPENSE;
      CHANGE:   state_d = credit_q <= CREDIT_W'(1) ? IDLE : CHANGE;
      default:  state_d = IDLE;
    endcase
  end
  // Coins are only accepted in IDLE/CREDIT, so the three credit sources never overlap.
  always_comb begin
    credit_d = ack ? left
             : (state_q == CHANGE && credit_q != '0) ? credit_q - CREDIT_W'(1)
             : coin_ok ? sum[CREDIT_W-1:0] : credit_q;
    change_d = state_q == CHANGE && credit_q != '0;
    reject_d = coin != COIN_NONE && !coin_ok;
    disp_req_d = state_d == DISPENSE;
    disp_id_d = grant ? g_idx : disp_id_q;
    fault_d = fault_q | tmo;
    timer_d = state_q == DISPENSE ? timer_q + TW'(1) : '0;
    for (int i = 0; i < N_PROD; i++) begin
      sold_out_d[i] = !restock_ok && stock_q[i] == '0;
      stock_d[i] = restock_ok ? STOCK_W'(STOCK_INIT)
                 : (ack && disp_id_q == IW'(i) && stock_q[i] != '0) ? stock_q[i] - STOCK_W'(1)
                 : stock_q[i];
    end
  end
  assign disp_req = disp_req_q;
  assign disp_id = disp_id_q;
  assign change_pulse = change_q;
  assign coin_reject = reject_q;
  assign credit = credit_q;
  assign sold_out = sold_out_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed self-checking bench for the vending controller
module tb_vend_ctrl;
  import vend_pkg::*;
  logic clk = 0, rst = 1, cancel = 0, restock = 0, disp_ack = 0;
  logic [1:0] coin = 0;
  logic [3:0] sel = 0;
  logic disp_req, change_pulse, coin_reject, fault;
  logic [1:0] disp_id;
  logic [3:0] credit, sold_out;
  int checks = 0, errors = 0, cnt;
  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel),
    .restock(restock), .disp_ack(disp_ack), .disp_req(disp_req),
    .disp_id(disp_id), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .credit(credit), .sold_out(sold_out), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pay(input logic [1:0] v);
    coin = v;
    step();
    coin = 0;
  endtask
  task automatic pulses(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      c += int'(change_pulse);
    end
  endtask
  task automatic ack_now();
    disp_ack = 1;
    step();
    disp_ack = 0;
  endtask
  initial begin
    step(); step();
    rst = 0;
    step();
    chk("rst_credit", 32'(credit), 0);
    chk("rst_req", 32'(disp_req), 0);
    chk("rst_sold", 32'(sold_out), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    // exact pay
    pay(2);
    chk("t1_credit2", 32'(credit), 2);
    chk("t1_state", 32'(dut.state_q), 32'(CREDIT));
    pay(1);
    chk("t1_credit3", 32'(credit), 3);
    sel = 4'b0010;
    step();
    sel = 0;
    chk("t1_req", 32'(disp_req), 1);
    chk("t1_id", 32'(disp_id), 1);
    step(); step();
    chk("t1_req_held", 32'(disp_req), 1);
    ack_now();
    chk("t1_credit0", 32'(credit), 0);
    chk("t1_req_drop", 32'(disp_req), 0);
    chk("t1_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t1_stock1", 32'(dut.stock_q[1]), 1);
    pulses(3, cnt);
    chk("t1_no_change", 32'(cnt), 0);
    // overpay with change
    pay(2); pay(2);
    chk("t2_credit4", 32'(credit), 4);
    sel = 4'b0001;
    step();
    sel = 0;
    chk("t2_id", 32'(disp_id), 0);
    ack_now();
    chk("t2_credit1", 32'(credit), 1);
    chk("t2_change_state", 32'(dut.state_q), 32'(CHANGE));
    pulses(4, cnt);
    chk("t2_pulses", 32'(cnt), 1);
    chk("t2_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t2_credit0", 32'(credit), 0);
    // arbitration with sold-out product 0
    pay(2); pay(1);
    sel = 4'b0001;
    step();
    sel = 0;
    ack_now();
    chk("t3_stock0", 32'(dut.stock_q[0]), 0);
    step();
    chk("t3_sold0", 32'(sold_out), 32'b0001);
    pay(2); pay(1);
    sel = 4'b0011;
    step();
    sel = 0;
    chk("t3_req", 32'(disp_req), 1);
    chk("t3_id", 32'(disp_id), 1);
    ack_now();
    step(); step();
    chk("t3_sold01", 32'(sold_out), 32'b0011);
    // cancel plus coin, bad coin
    pay(2);
    coin = 1;
    cancel = 1;
    step();
    coin = 0;
    cancel = 0;
    chk("t4_reject", 32'(coin_reject), 1);
    chk("t4_credit_kept", 32'(credit), 2);
    pulses(4, cnt);
    chk("t4_pulses", 32'(cnt), 2);
    chk("t4_credit0", 32'(credit), 0);
    pay(3);
    chk("t4_bad_reject", 32'(coin_reject), 1);
    chk("t4_bad_credit", 32'(credit), 0);
    chk("t4_bad_idle", 32'(dut.state_q), 32'(IDLE));
    step();
    chk("t4_reject_pulse", 32'(coin_reject), 0);
    // dispense timeout
    pay(2); pay(1);
    sel = 4'b0100;
    step();
    sel = 0;
    chk("t5_id", 32'(disp_id), 2);
    for (int i = 0; i < 7; i++) step();
    chk("t5_req_at7", 32'(disp_req), 1);
    chk("t5_nofault_at7", 32'(fault), 0);
    step();
    chk("t5_fault", 32'(fault), 1);
    chk("t5_req_drop", 32'(disp_req), 0);
    chk("t5_credit_kept", 32'(credit), 3);
    pulses(5, cnt);
    chk("t5_pulses", 32'(cnt), 3);
    chk("t5_stock2", 32'(dut.stock_q[2]), 2);
    pay(2); pay(1);
    sel = 4'b0100;
    step();
    sel = 0;
    chk("t5_no_grant", 32'(disp_req), 0);
    chk("t5_credit_state", 32'(dut.state_q), 32'(CREDIT));
    cancel = 1;
    step();
    cancel = 0;
    pulses(4, cnt);
    chk("t5_refund", 32'(cnt), 3);
    // overflow and restock
    for (int i = 0; i < 7; i++) pay(2);
    chk("t6_credit14", 32'(credit), 14);
    pay(2);
    chk("t6_ovf_reject", 32'(coin_reject), 1);
    chk("t6_credit_kept", 32'(credit), 14);
    cancel = 1;
    step();
    cancel = 0;
    pulses(16, cnt);
    chk("t6_refund", 32'(cnt), 14);
    chk("t6_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t6_sold_before", 32'(sold_out), 32'b0011);
    restock = 1;
    step();
    restock = 0;
    step();
    chk("t6_sold_cleared", 32'(sold_out), 0);
    chk("t6_stock0", 32'(dut.stock_q[0]), 2);
    chk("t6_fault_sticky", 32'(fault), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
